button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised input conditioner for the SLC-3 board push-buttons (Run, Continue and any added keys).
- Takes raw active-low button lines and produces synchronised, debounced levels, one-cycle press/release strobes, optional auto-repeat strobes and an all-keys chord flag.
- Sits between the top-level button pins and the CPU control logic, replacing ad-hoc per-button synchronisers with one block that scales in channel count.

Parameters:
N_CH, 2, number of independent button channels
SYNC_STAGES, 2, synchroniser flop depth per channel (min 2)
DB_CYCLES, 4, consecutive stable synced cycles required to accept a level change (board builds use 500000)
REPEAT_CYCLES, 0, auto-repeat period in cycles while held; 0 disables repeat
CNT_W, derived (localparam), ceil(log2(max(DB_CYCLES, REPEAT_CYCLES)+1))

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
btn_n  input  N_CH  raw button lines, 0 = pressed, asynchronous to Clk
level  output  N_CH  debounced state, 1 = pressed
press  output  N_CH  one-cycle strobe on accepted press, and on each auto-repeat
release  output  N_CH  one-cycle strobe on accepted release
chord  output  1  registered; 1 while every level bit is 1 (reset-combo detect)

Behaviour:
- Reset (Reset_n=0, asynchronous): synchroniser flops set to 1 (unpressed). level, press, release and chord = 0. All counters = 0. Outputs are held for the whole reset duration.
- Reset deassertion mid-press: the button is treated as newly pressed. No release strobe is generated for the pre-reset state.
- Synchroniser: per channel, SYNC_STAGES flops in series. syn = inverted last stage (1 = pressed).
- Debounce FSM per channel. States:
  - STABLE_UP: level 0. Entered at reset.
  - WAIT_DOWN: syn=1, counting.
  - STABLE_DOWN: level 1.
  - WAIT_UP: syn=0, counting.
- Transitions:
  - STABLE_UP→WAIT_DOWN when syn=1, db_cnt := 1.
  - In WAIT_DOWN, syn=1 increments db_cnt. syn=0 returns to STABLE_UP with db_cnt := 0, giving glitch rejection with no output change.
  - When syn=1 and db_cnt = DB_CYCLES-1, go to STABLE_DOWN and set level := 1, press := 1 on that same edge.
  - WAIT_UP mirrors WAIT_DOWN. On acceptance, level := 0 and release := 1.
- Latency: count the first rising edge sampling btn_n=0 as edge 0. level rises on edge SYNC_STAGES+DB_CYCLES-1, which is edge 5 with the defaults. Release latency is identical.
- Pulses shorter than DB_CYCLES synced cycles never change level or emit strobes. press and release are never both 1 in the same cycle for one channel.
- Auto-repeat, active only when REPEAT_CYCLES>0:
  - rep_cnt clears on the press-acceptance edge.
  - rep_cnt increments each cycle in STABLE_DOWN or WAIT_UP.
  - When rep_cnt = REPEAT_CYCLES-1, press := 1 for one cycle and rep_cnt := 0.
  - Acceptance of the release clears rep_cnt, and no further repeat strobes are issued.
  - The first repeat occurs REPEAT_CYCLES cycles after the initial press strobe.
- chord: registered from level, so it asserts 1 cycle after the last level bit rises. It deasserts 1 cycle after any level bit falls.
- Channels are fully independent. Simultaneous presses on several channels produce same-cycle strobes.
- Counters saturate by construction. No wrap is reachable.

Test Plan:
1. Reset values: hold Reset_n=0 with btn_n=2'b00 -> level=0, press=0, release=0, chord=0. Release reset with btn_n held at 00 -> both level bits rise on edge 5 after deassertion, with exactly one press strobe each and no release strobes.
2. Clean press/release on ch0 (defaults): btn_n[0] low for 20 cycles -> level[0]=1 from edge 5, a single-cycle press[0] on edge 5. After btn_n[0] returns high, level[0]=0 after 5 edges with a single release[0]. Ch1 stays quiet.
3. Glitch rejection: btn_n[1] low for 3 cycles, high 1 cycle, low 3 cycles, then high -> level[1] never rises, and no press or release strobes appear.
4. Bounce then settle: ch0 toggles every cycle for 6 cycles, then stays low -> exactly one press[0], asserted 5 edges after the last toggle.
5. Chord and auto-repeat (REPEAT_CYCLES=8): press both channels 2 cycles apart and hold 40 cycles -> chord rises 1 cycle after level[1]. Each channel gives its initial press strobe plus repeats every 8 cycles. Releasing either channel drops chord and stops that channel's repeats.
6. Async reset mid-hold: assert Reset_n=0 between clock edges while both channels are held -> level and chord go to 0 immediately. After deassertion with the buttons still held, each channel produces a fresh press strobe after 5 edges and no spurious release.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release strobes,
// optional auto-repeat and an all-keys chord flag.
module button_conditioner #(
    parameter int N_CH          = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [N_CH-1:0] btn_n,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] o_release,
    output logic            chord
);

    localparam int MAXV  = (DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = (MAXV < 1) ? 1 : $clog2(MAXV + 1);
    localparam logic [CNT_W-1:0] ZERO     = '0;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        STABLE_UP,
        WAIT_DOWN,
        STABLE_DOWN,
        WAIT_UP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync [N_CH];
    state_t                 r_state [N_CH];
    logic [CNT_W-1:0]       r_db_cnt [N_CH];
    logic [CNT_W-1:0]       r_rep_cnt [N_CH];
    logic [N_CH-1:0]        r_level;
    logic [N_CH-1:0]        r_press;
    logic [N_CH-1:0]        r_release;
    logic                   r_chord;
    logic [N_CH-1:0]        w_syn;

    // Synchroniser flops reset to the idle (released) line level
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < N_CH; c++) r_sync[c] <= '1;
        end else begin
            for (int c = 0; c < N_CH; c++)
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], btn_n[c]};
        end
    end

    always_comb begin
        w_syn = '0;
        for (int c = 0; c < N_CH; c++) w_syn[c] = ~r_sync[c][SYNC_STAGES-1];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c]   <= STABLE_UP;
                r_db_cnt[c]  <= ZERO;
                r_rep_cnt[c] <= ZERO;
            end
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_press[c]   <= 1'b0;
                r_release[c] <= 1'b0;
                unique case (r_state[c])
                    STABLE_UP: begin
                        if (w_syn[c]) begin
                            if (DB_CYCLES <= 1) begin
                                r_state[c]   <= STABLE_DOWN;
                                r_level[c]   <= 1'b1;
                                r_press[c]   <= 1'b1;
                                r_rep_cnt[c] <= ZERO;
                            end else begin
                                r_state[c]  <= WAIT_DOWN;
                                r_db_cnt[c] <= ONE;
                            end
                        end
                    end
                    WAIT_DOWN: begin
                        if (!w_syn[c]) begin
                            r_state[c]  <= STABLE_UP;
                            r_db_cnt[c] <= ZERO;
                        end else if (r_db_cnt[c] == DB_LAST) begin
                            r_state[c]   <= STABLE_DOWN;
                            r_db_cnt[c]  <= ZERO;
                            r_level[c]   <= 1'b1;
                            r_press[c]   <= 1'b1;
                            r_rep_cnt[c] <= ZERO;
                        end else begin
                            r_db_cnt[c] <= r_db_cnt[c] + ONE;
                        end
                    end
                    STABLE_DOWN, WAIT_UP: begin
                        // Repeat runs while held; a release acceptance below overrides it
                        if (REPEAT_CYCLES > 0) begin
                            if (r_rep_cnt[c] == REP_LAST) begin
                                r_rep_cnt[c] <= ZERO;
                                r_press[c]   <= 1'b1;
                            end else begin
                                r_rep_cnt[c] <= r_rep_cnt[c] + ONE;
                            end
                        end
                        if (r_state[c] == STABLE_DOWN) begin
                            if (!w_syn[c]) begin
                                if (DB_CYCLES <= 1) begin
                                    r_state[c]   <= STABLE_UP;
                                    r_level[c]   <= 1'b0;
                                    r_release[c] <= 1'b1;
                                    r_press[c]   <= 1'b0;
                                    r_rep_cnt[c] <= ZERO;
                                end else begin
                                    r_state[c]  <= WAIT_UP;
                                    r_db_cnt[c] <= ONE;
                                end
                            end
                        end else if (w_syn[c]) begin
                            r_state[c]  <= STABLE_DOWN;
                            r_db_cnt[c] <= ZERO;
                        end else if (r_db_cnt[c] == DB_LAST) begin
                            r_state[c]   <= STABLE_UP;
                            r_db_cnt[c]  <= ZERO;
                            r_level[c]   <= 1'b0;
                            r_release[c] <= 1'b1;
                            r_press[c]   <= 1'b0;
                            r_rep_cnt[c] <= ZERO;
                        end else begin
                            r_db_cnt[c] <= r_db_cnt[c] + ONE;
                        end
                    end
                    default: r_state[c] <= STABLE_UP;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_chord <= 1'b0;
        else          r_chord <= &r_level;
    end

    assign level     = r_level;
    assign press     = r_press;
    assign o_release = r_release;
    assign chord     = r_chord;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: default build plus a repeat build.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] lvl, prs, rel;
    logic       chd;
    logic [1:0] btn_r = 2'b11;
    logic [1:0] lvl_r, prs_r, rel_r;
    logic       chd_r;

    int checks = 0;
    int errors = 0;

    logic [6:0] obs, obs_r, exp_v;

    assign obs   = {lvl, prs, rel, chd};
    assign obs_r = {lvl_r, prs_r, rel_r, chd_r};

    button_conditioner dut (
        .Clk(clk), .Reset_n(rst_n), .btn_n(btn_n),
        .level(lvl), .press(prs), .o_release(rel), .chord(chd)
    );

    button_conditioner #(.REPEAT_CYCLES(8)) dut_r (
        .Clk(clk), .Reset_n(rst_n), .btn_n(btn_r),
        .level(lvl_r), .press(prs_r), .o_release(rel_r), .chord(chd_r)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_n = 2'b11;
        btn_r = 2'b11;
        repeat (12) step();
    endtask

    // Both channels held through reset release: fresh press at edge 5
    task automatic check_fresh_press(input string name);
        for (int k = 0; k < 10; k++) begin
            step();
            exp_v = {(k >= 5) ? 2'b11 : 2'b00,
                     (k == 5) ? 2'b11 : 2'b00,
                     2'b00, (k >= 6)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s k=%0d got %b want %b", name, k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_n = 2'b00;
        repeat (3) begin
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold got %b want %b", obs, 7'b0);
            end
        end
        rst_n = 1'b1;
        check_fresh_press("reset_release");
        settle();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_clean_press();
        btn_n[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            exp_v = {1'b0, k >= 5, 1'b0, k == 5, 2'b00, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clean_press k=%0d got %b want %b", k, obs, exp_v);
            end
        end
        btn_n[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_v = {1'b0, k < 5, 2'b00, 1'b0, k == 5, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clean_release k=%0d got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 20; k++) begin
            btn_n[1] = (k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL glitch k=%0d got %b want %b", k, obs, 7'b0);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 21; k++) begin
            btn_n[0] = (k < 6) ? k[0] : 1'b0;
            step();
            exp_v = {1'b0, k >= 11, 1'b0, k == 11, 2'b00, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce k=%0d got %b want %b", k, obs, exp_v);
            end
        end
        settle();
    endtask

    task automatic test_chord_repeat();
        logic l0, l1, p0, p1, r0, c;
        for (int n = 0; n < 60; n++) begin
            btn_r[0] = (n < 42) ? 1'b0 : 1'b1;
            btn_r[1] = (n < 2) ? 1'b1 : 1'b0;
            step();
            l0 = (n >= 5) && (n < 47);
            l1 = (n >= 7);
            p0 = (n >= 5) && (n < 47) && ((n - 5) % 8 == 0);
            p1 = (n >= 7) && ((n - 7) % 8 == 0);
            r0 = (n == 47);
            c  = (n >= 8) && (n < 48);
            exp_v = {l1, l0, p1, p0, 1'b0, r0, c};
            checks++;
            if (obs_r !== exp_v) begin
                errors++;
                $display("FAIL chord_repeat n=%0d got %b want %b", n, obs_r, exp_v);
            end
        end
        settle();
        checks++;
        if (obs_r !== 7'b0) begin
            errors++;
            $display("FAIL repeat_idle got %b want %b", obs_r, 7'b0);
        end
    endtask

    task automatic test_async_reset();
        btn_n = 2'b00;
        repeat (12) step();
        checks++;
        if (obs !== 7'b1100001) begin
            errors++;
            $display("FAIL held_pre got %b want %b", obs, 7'b1100001);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL async_assert got %b want %b", obs, 7'b0);
        end
        repeat (2) begin
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL async_hold got %b want %b", obs, 7'b0);
            end
        end
        rst_n = 1'b1;
        check_fresh_press("async_release");
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_chord_repeat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
